// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp bank's thermometer encoder/decoder pair.
// Holds the lamp count, the scan index width and the decoder FSM encoding.
package lamp_pkg;

    localparam int LAMP_COUNT = 16;
    localparam int LAMP_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } lamp_state_e;

endpackage

// File: rtl/lamp_shift_reg.sv
// Parallel-load, right-shift register. It presents the current lowest lamp on lsb_o.
// Load takes priority over shift.
module lamp_shift_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         lsb_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end else if (shift_i) begin
            data_q <= {1'b0, data_q[W-1:1]};
        end
    end

    assign lsb_o = data_q[0];

endmodule

// File: rtl/lamp_scan_decoder.sv
// Serial thermometer-code decoder. It scans one lamp per clock from lamp 0 upward,
// reports the leading on-run length and flags any word that is not a legal code.
module lamp_scan_decoder
    import lamp_pkg::*;
#(
    parameter int LAMPS = LAMP_COUNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LAMPS-1:0]  lights_state,
    output logic              busy,
    output logic              done,
    output logic [3:0]        active_lights,
    output logic              thermo_error,
    output lamp_state_e       dbg_state
);

    localparam logic [LAMP_IDX_W-1:0] LAST_IDX = LAMP_IDX_W'(LAMPS - 1);

    lamp_state_e             state_q;
    logic [LAMP_IDX_W-1:0]   idx_q;
    logic [3:0]              run_q;
    logic                    seen_off_q;
    logic                    err_q;
    logic                    busy_q;
    logic                    done_q;
    logic [3:0]              active_q;
    logic                    therr_q;

    logic                    load_d;
    logic                    shift_d;
    logic                    lamp_on;

    // Capture and shift are decoded from the current state so the shift
    // register moves in lock-step with the index.
    assign load_d  = (state_q == IDLE) && start;
    assign shift_d = (state_q == SCAN);

    lamp_shift_reg #(
        .W (LAMPS)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load_d),
        .shift_i (shift_d),
        .data_i  (lights_state),
        .lsb_o   (lamp_on)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            run_q      <= '0;
            seen_off_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            active_q   <= '0;
            therr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        idx_q      <= '0;
                        run_q      <= '0;
                        seen_off_q <= 1'b0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + 1'b1;
                    // Lamp 15 is never part of a legal run, so it only
                    // contributes to the error flag and the counter cannot wrap.
                    if (idx_q == LAST_IDX) begin
                        if (lamp_on) begin
                            err_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end else if (lamp_on) begin
                        if (seen_off_q) begin
                            err_q <= 1'b1;
                        end else begin
                            run_q <= run_q + 1'b1;
                        end
                    end else begin
                        seen_off_q <= 1'b1;
                    end
                end
                DONE: begin
                    active_q <= run_q;
                    therr_q  <= err_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign active_lights = active_q;
    assign thermo_error  = therr_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/lamp_scan_decoder.md
# lamp_scan_decoder

Serial decoder for the lamp bank's thermometer-coded state vector. It is the inverse of the count-to-lamps encoder. On a start request it captures a 16-bit lamp-state word, scans it one lamp per clock from lamp 0 upward, and returns the number of active lamps. It flags any word that is not a legal thermometer code. It sits on the readback path between the lamp driver and the control logic that needs the active-lamp count.

## Interface
- `LAMPS`, default 16: number of lamps scanned. Fixed at 16 for this revision.
- `clk` input 1: single system clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: scan request. Sampled only in IDLE.
- `lights_state` input 16: lamp-state word. Bit i is lamp i, 1 means on. Sampled on the accepted `start` edge only.
- `busy` output 1: high from the accepted start until the cycle before `done`.
- `done` output 1: one-cycle pulse when the result is valid.
- `active_lights` output 4: decoded active-lamp count, range 0..15.
- `thermo_error` output 1: the captured word was not a legal code.

## Operation
- Legal code: lamps 0..N-1 on and lamps N..15 off, with N in 0..15. Lamp 15 is never on in a legal word.
- FSM states: IDLE, SCAN, DONE.
- IDLE, `start`=1:
  - Capture `lights_state` into a 16-bit shift register.
  - Clear the scan index, run counter, `seen_off` and the error accumulator.
  - Go to SCAN.
- IDLE, `start`=0: stay in IDLE.
- SCAN, each cycle: examine shift-register bit 0, then shift right by one and increment the index.
  - Bit 1 and `seen_off`=0: run counter +1.
  - Bit 1 and `seen_off`=1: set error (bubble).
  - Bit 0: set `seen_off`.
  - When the index reaches 15 (lamp 15): set error if the bit is 1, go to DONE.
- Run counter is 4 bits. It counts only the contiguous run of on-lamps starting at lamp 0. Lamp 15 never increments it, so it cannot wrap.
- DONE: load `active_lights` from the run counter and `thermo_error` from the accumulator, pulse `done`, go to IDLE.
- On an error, `active_lights` still reports the leading-run length.
- `active_lights` and `thermo_error` hold their values until the next DONE. Busy/done state does not change them.
- `start` while busy (SCAN or DONE) is ignored. It is neither queued nor does it restart the scan.
- `lights_state` changes after capture have no effect on the running scan.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `active_lights`=0, `thermo_error`=0. Shift register, index and counters are also 0.
- `reset` asserted mid-scan aborts the scan immediately and asynchronously. Outputs return to their reset values and no `done` is issued.
- Edge numbering, with `start` sampled high at edge 0:
  - Edge 0: `busy` goes high.
  - Edges 1..16: the 16 SCAN cycles (lamp i examined at edge i+1).
  - Edge 17: DONE is entered.
  - After edge 17: `done`=1 and `busy`=0 for one cycle.
  - After edge 18: `done`=0. `active_lights` and `thermo_error` are valid from edge 17 onward.
- Fixed latency: 17 cycles from start acceptance to `done`, independent of the data.
- Back-to-back: a `start` held high during the DONE cycle is accepted at edge 18. Sustained throughput is one scan per 18 cycles.

## Structure
- Shared package `lamp_pkg` holds:
  - `LAMP_COUNT`=16
  - `LAMP_IDX_W`=4
  - FSM state typedef and encodings: IDLE=2'b00, SCAN=2'b01, DONE=2'b10
- The encoder side of the same interface uses the same package.
- One natural sub-module, `lamp_shift_reg`: 16-bit parallel-load, right-shift register with load/shift enables. Everything else stays in the top-level FSM.

## Test plan
- Reset, then `start` with `lights_state`=16'h0000 → `done` 17 cycles after acceptance, `active_lights`=0, `thermo_error`=0.
- 16'h00FF → `active_lights`=8, `thermo_error`=0.
- 16'h7FFF → `active_lights`=15, `thermo_error`=0.
- 16'h0105 (bubble) → `active_lights`=1, `thermo_error`=1.
- 16'h8000 → `active_lights`=0, `thermo_error`=1.
- Start-during-busy and reset:
  - Start 16'h000F, pulse `start` again at cycle 5 with 16'hFFFF → one `done` only, `active_lights`=4.
  - Start a new scan and assert `reset` at cycle 9 → no `done`, all outputs 0.
  - Next `start` after reset releases → normal 17-cycle result.
